mmio_bus_arbiter: RTL and testbench
===================================

Name: mmio_bus_arbiter

Overview:
Shares the single memory-mapped peripheral bus between two requesters:
- m0 is the CPU data port.
- m1 is a debug/DMA port.

Peripherals such as the cycle/performance counter are decoded downstream, so each peripheral sees exactly one transaction at a time. The block provides round-robin arbitration, alignment checking, a timeout guard and a registered one-cycle acknowledge back to the winning requester.

Parameters:
TIMEOUT, 15, number of BUSY cycles without s_ready before the transaction is aborted with error (1..255)
ADDR_W, 32, address width
DATA_W, 32, data width

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
m0_req  in  1  requester 0 transaction request; held until m0_ack
m0_addr  in  ADDR_W  requester 0 byte address
m0_wdata  in  DATA_W  requester 0 write data
m0_size  in  2  00 none, 01 byte, 10 half, 11 word
m0_rw  in  1  1 write, 0 read
m0_rdata  out  DATA_W  read data, valid while m0_ack=1
m0_ack  out  1  one-cycle completion pulse
m0_err  out  1  error flag, valid while m0_ack=1
m1_*  (same set as m0_*)
s_valid  out  1  slave transaction strobe
s_addr  out  ADDR_W  slave address
s_wdata  out  DATA_W  slave write data
s_size  out  2  slave access size
s_rw  out  1  slave direction
s_rdata  in  DATA_W  slave read data, sampled when s_ready=1
s_ready  in  1  slave completion

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, timeout counter=0, last_grant=1 (so m0 wins the first tie).
  - All outputs are 0: s_valid, s_addr, s_wdata, s_size, s_rw, m*_ack, m*_err, m*_rdata.
- FSM states:
  - IDLE:
    - No request: stay in IDLE.
    - Exactly one request: grant it.
    - Both requesting: grant the requester that is not last_grant; update last_grant.
    - On grant, latch addr/wdata/size/rw into s_* registers and check the request.
    - Request checks: size=00 is an error; size=10 with addr[0]=1 is misaligned; size=11 with addr[1:0]!=0 is misaligned.
    - Invalid request: go to RESP with err=1, rdata=0; s_valid is never asserted.
    - Valid request: go to BUSY with s_valid=1 on the next cycle.
  - BUSY:
    - s_valid=1; s_* outputs hold their latched values.
    - s_ready=1: capture s_rdata (reads only; writes return 0), go to RESP.
    - Otherwise increment tcnt. When tcnt==TIMEOUT-1 with no ready, go to RESP with err=1, rdata=0.
    - s_valid drops on the exit edge.
  - RESP:
    - Granted m*_ack=1 for exactly one cycle; m*_err and m*_rdata are valid in that cycle.
    - The other requester's ack=0.
    - Then go to IDLE, clear tcnt, and zero m*_rdata/err.
- Latency:
  - Request sampled in IDLE at edge N → s_valid high from N+1.
  - s_ready sampled at edge M → ack high from M+1 for one cycle.
  - Minimum 3 cycles from req to ack (s_ready in the first BUSY cycle); throughput at most one transaction per 3 cycles.
- Simultaneous events:
  - s_ready in the same cycle the timeout fires: ready wins, err=0.
  - Requests arriving while not in IDLE wait; no request is lost while req stays high.
- Requester drops req mid-transaction: the transaction still completes and ack is still pulsed (tolerated protocol violation).
- Reset mid-BUSY: abandons the transaction; no ack, s_valid=0 immediately.
- Fairness: under continuous requests from both masters, grants strictly alternate.
- s_ready while not in BUSY is ignored.

Decomposition:
- Shared package mmio_pkg:
  - size encodings SZ_NONE/SZ_BYTE/SZ_HALF/SZ_WORD
  - RW_READ=0 / RW_WRITE=1
  - state enum IDLE/BUSY/RESP
- One sub-module, rr_arbiter2: combinational grant from req[1:0] and last_grant, plus a registered last_grant update on the accept strobe.
- Alignment check is an inline function in mmio_pkg.

Test Plan:
- m0 read word addr 0x8000_0000, slave ready one cycle after s_valid with s_rdata=0x0000_002A → s_valid for 2 cycles, m0_ack one cycle with m0_rdata=0x2A, m0_err=0, m1_ack=0.
- m0 and m1 both assert continuously, slave always ready → grants alternate m0,m1,m0,m1; each ack spaced 3 cycles apart.
- m1 half-word write addr 0x8000_0001 → no s_valid, m1_ack with m1_err=1 two cycles after req; same response for size=00.
- m0 read with s_ready held low, TIMEOUT=15 → s_valid high exactly 15 cycles, then m0_ack with m0_err=1, m0_rdata=0.
- s_ready asserted exactly on the 15th BUSY cycle → err=0, data returned.
- rst_n pulsed low mid-BUSY → s_valid and all acks drop asynchronously; after release, the first tie grants m0.

Source files
------------

// File: rtl/mmio_pkg.sv
// Shared encodings and request checks for the MMIO bus arbiter.
package mmio_pkg;

   localparam logic [1:0] SZ_NONE = 2'b00;
   localparam logic [1:0] SZ_BYTE = 2'b01;
   localparam logic [1:0] SZ_HALF = 2'b10;
   localparam logic [1:0] SZ_WORD = 2'b11;

   localparam logic RW_READ  = 1'b0;
   localparam logic RW_WRITE = 1'b1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      RESP = 2'd2
   } state_e;

   // A request is legal only with a real size and natural alignment.
   function automatic logic req_valid(input logic [1:0] size, input logic [1:0] addr_lo);
      case (size)
         SZ_BYTE: req_valid = 1'b1;
         SZ_HALF: req_valid = ~addr_lo[0];
         SZ_WORD: req_valid = (addr_lo == 2'b00);
         default: req_valid = 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter; last_grant advances only when a grant is accepted.
module rr_arbiter2 (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [1:0] req,
   input  logic       accept,
   output logic       gnt_valid,
   output logic       gnt_idx
);

   logic last_grant_q;
   logic last_grant_d;

   // Grant selection; on a tie the requester not served last wins.
   always_comb begin
      gnt_valid    = |req;
      gnt_idx      = 1'b0;
      last_grant_d = last_grant_q;
      case (req)
         2'b01:   gnt_idx = 1'b0;
         2'b10:   gnt_idx = 1'b1;
         2'b11:   gnt_idx = ~last_grant_q;
         default: gnt_idx = 1'b0;
      endcase
      if (accept) begin
         last_grant_d = gnt_idx;
      end else begin
         last_grant_d = last_grant_q;
      end
   end

   // Reset value 1 lets m0 win the first tie.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         last_grant_q <= 1'b1;
      end else begin
         last_grant_q <= last_grant_d;
      end
   end

endmodule

// File: rtl/mmio_bus_arbiter.sv
// Shares one MMIO slave bus between two requesters with alignment checks,
// a timeout guard and a registered one-cycle acknowledge.
module mmio_bus_arbiter
   import mmio_pkg::*;
#(
   parameter int unsigned TIMEOUT = 15,
   parameter int unsigned ADDR_W  = 32,
   parameter int unsigned DATA_W  = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              m0_req,
   input  logic [ADDR_W-1:0] m0_addr,
   input  logic [DATA_W-1:0] m0_wdata,
   input  logic [1:0]        m0_size,
   input  logic              m0_rw,
   output logic [DATA_W-1:0] m0_rdata,
   output logic              m0_ack,
   output logic              m0_err,
   input  logic              m1_req,
   input  logic [ADDR_W-1:0] m1_addr,
   input  logic [DATA_W-1:0] m1_wdata,
   input  logic [1:0]        m1_size,
   input  logic              m1_rw,
   output logic [DATA_W-1:0] m1_rdata,
   output logic              m1_ack,
   output logic              m1_err,
   output logic              s_valid,
   output logic [ADDR_W-1:0] s_addr,
   output logic [DATA_W-1:0] s_wdata,
   output logic [1:0]        s_size,
   output logic              s_rw,
   input  logic [DATA_W-1:0] s_rdata,
   input  logic              s_ready
);

   localparam logic [7:0] T_LAST = 8'(TIMEOUT - 1);

   state_e            state_q, state_d;
   logic [7:0]        tcnt_q, tcnt_d;
   logic              gidx_q, gidx_d;
   logic              s_valid_q, s_valid_d;
   logic [ADDR_W-1:0] s_addr_q, s_addr_d;
   logic [DATA_W-1:0] s_wdata_q, s_wdata_d;
   logic [1:0]        s_size_q, s_size_d;
   logic              s_rw_q, s_rw_d;
   logic [1:0]        ack_q, ack_d;
   logic [1:0]        err_q, err_d;
   logic [DATA_W-1:0] m0_rdata_q, m0_rdata_d;
   logic [DATA_W-1:0] m1_rdata_q, m1_rdata_d;

   logic              arb_valid;
   logic              arb_idx;
   logic              accept;
   logic [ADDR_W-1:0] sel_addr;
   logic [DATA_W-1:0] sel_wdata;
   logic [1:0]        sel_size;
   logic              sel_rw;

   rr_arbiter2 u_arb (
      .clk       (clk),
      .rst_n     (rst_n),
      .req       ({m1_req, m0_req}),
      .accept    (accept),
      .gnt_valid (arb_valid),
      .gnt_idx   (arb_idx)
   );

   // Next-state and datapath for the IDLE/BUSY/RESP transaction sequencer.
   always_comb begin
      state_d    = state_q;
      tcnt_d     = tcnt_q;
      gidx_d     = gidx_q;
      s_valid_d  = s_valid_q;
      s_addr_d   = s_addr_q;
      s_wdata_d  = s_wdata_q;
      s_size_d   = s_size_q;
      s_rw_d     = s_rw_q;
      ack_d      = ack_q;
      err_d      = err_q;
      m0_rdata_d = m0_rdata_q;
      m1_rdata_d = m1_rdata_q;
      accept     = 1'b0;
      sel_addr   = arb_idx ? m1_addr  : m0_addr;
      sel_wdata  = arb_idx ? m1_wdata : m0_wdata;
      sel_size   = arb_idx ? m1_size  : m0_size;
      sel_rw     = arb_idx ? m1_rw    : m0_rw;

      case (state_q)
         IDLE: begin
            if (arb_valid) begin
               accept    = 1'b1;
               gidx_d    = arb_idx;
               s_addr_d  = sel_addr;
               s_wdata_d = sel_wdata;
               s_size_d  = sel_size;
               s_rw_d    = sel_rw;
               tcnt_d    = 8'd0;
               if (req_valid(sel_size, sel_addr[1:0])) begin
                  state_d   = BUSY;
                  s_valid_d = 1'b1;
               end else begin
                  // Rejected requests answer immediately and never reach the slave.
                  state_d          = RESP;
                  ack_d[arb_idx]   = 1'b1;
                  err_d[arb_idx]   = 1'b1;
                  m0_rdata_d       = '0;
                  m1_rdata_d       = '0;
               end
            end else begin
               state_d = IDLE;
            end
         end
         BUSY: begin
            if (s_ready) begin
               state_d       = RESP;
               s_valid_d     = 1'b0;
               ack_d[gidx_q] = 1'b1;
               err_d[gidx_q] = 1'b0;
               if (gidx_q) begin
                  m1_rdata_d = (s_rw_q == RW_WRITE) ? '0 : s_rdata;
               end else begin
                  m0_rdata_d = (s_rw_q == RW_WRITE) ? '0 : s_rdata;
               end
            end else if (tcnt_q == T_LAST) begin
               state_d       = RESP;
               s_valid_d     = 1'b0;
               ack_d[gidx_q] = 1'b1;
               err_d[gidx_q] = 1'b1;
               m0_rdata_d    = '0;
               m1_rdata_d    = '0;
            end else begin
               tcnt_d = tcnt_q + 8'd1;
            end
         end
         RESP: begin
            state_d    = IDLE;
            tcnt_d     = 8'd0;
            ack_d      = 2'b00;
            err_d      = 2'b00;
            m0_rdata_d = '0;
            m1_rdata_d = '0;
         end
         default: begin
            state_d    = IDLE;
            tcnt_d     = 8'd0;
            s_valid_d  = 1'b0;
            ack_d      = 2'b00;
            err_d      = 2'b00;
            m0_rdata_d = '0;
            m1_rdata_d = '0;
         end
      endcase
   end

   // State and output registers; reset abandons any transaction in flight.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         tcnt_q     <= 8'd0;
         gidx_q     <= 1'b0;
         s_valid_q  <= 1'b0;
         s_addr_q   <= '0;
         s_wdata_q  <= '0;
         s_size_q   <= 2'b00;
         s_rw_q     <= 1'b0;
         ack_q      <= 2'b00;
         err_q      <= 2'b00;
         m0_rdata_q <= '0;
         m1_rdata_q <= '0;
      end else begin
         state_q    <= state_d;
         tcnt_q     <= tcnt_d;
         gidx_q     <= gidx_d;
         s_valid_q  <= s_valid_d;
         s_addr_q   <= s_addr_d;
         s_wdata_q  <= s_wdata_d;
         s_size_q   <= s_size_d;
         s_rw_q     <= s_rw_d;
         ack_q      <= ack_d;
         err_q      <= err_d;
         m0_rdata_q <= m0_rdata_d;
         m1_rdata_q <= m1_rdata_d;
      end
   end

   assign s_valid  = s_valid_q;
   assign s_addr   = s_addr_q;
   assign s_wdata  = s_wdata_q;
   assign s_size   = s_size_q;
   assign s_rw     = s_rw_q;
   assign m0_ack   = ack_q[0];
   assign m1_ack   = ack_q[1];
   assign m0_err   = err_q[0];
   assign m1_err   = err_q[1];
   assign m0_rdata = m0_rdata_q;
   assign m1_rdata = m1_rdata_q;

endmodule

// File: tb/tb_mmio_bus_arbiter.sv
// Directed self-checking bench for mmio_bus_arbiter.
module tb_mmio_bus_arbiter;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        m0_req, m1_req;
   logic [31:0] m0_addr, m1_addr, m0_wdata, m1_wdata;
   logic [1:0]  m0_size, m1_size;
   logic        m0_rw, m1_rw;
   logic [31:0] m0_rdata, m1_rdata;
   logic        m0_ack, m1_ack, m0_err, m1_err;
   logic        s_valid;
   logic [31:0] s_addr, s_wdata;
   logic [1:0]  s_size;
   logic        s_rw;
   logic [31:0] s_rdata;
   logic        s_ready;

   int checks   = 0;
   int failures = 0;
   int vcnt;
   bit got;

   always #5 clk = ~clk;

   mmio_bus_arbiter #(.TIMEOUT(15), .ADDR_W(32), .DATA_W(32)) dut (
      .clk(clk), .rst_n(rst_n),
      .m0_req(m0_req), .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_size(m0_size),
      .m0_rw(m0_rw), .m0_rdata(m0_rdata), .m0_ack(m0_ack), .m0_err(m0_err),
      .m1_req(m1_req), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_size(m1_size),
      .m1_rw(m1_rw), .m1_rdata(m1_rdata), .m1_ack(m1_ack), .m1_err(m1_err),
      .s_valid(s_valid), .s_addr(s_addr), .s_wdata(s_wdata), .s_size(s_size),
      .s_rw(s_rw), .s_rdata(s_rdata), .s_ready(s_ready)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst_n = 1'b0;
      m0_req = 1'b0; m0_addr = 32'h0; m0_wdata = 32'h0; m0_size = 2'b00; m0_rw = 1'b0;
      m1_req = 1'b0; m1_addr = 32'h0; m1_wdata = 32'h0; m1_size = 2'b00; m1_rw = 1'b0;
      s_rdata = 32'h0; s_ready = 1'b0;
      step(); step();
      chk("rst_s_valid", 64'(s_valid), 64'd0);
      chk("rst_acks", 64'({m1_ack, m0_ack}), 64'd0);
      chk("rst_errs", 64'({m1_err, m0_err}), 64'd0);
      chk("rst_s_addr", 64'(s_addr), 64'd0);
      chk("rst_rdata", 64'(m0_rdata | m1_rdata), 64'd0);
      rst_n = 1'b1;
      step();

      // m0 word read, slave ready in the second BUSY cycle
      m0_req = 1'b1; m0_addr = 32'h8000_0000; m0_size = 2'b11; m0_rw = 1'b0;
      step();
      chk("rd_valid1", 64'(s_valid), 64'd1);
      chk("rd_s_addr", 64'(s_addr), 64'h8000_0000);
      chk("rd_ack_early", 64'(m0_ack), 64'd0);
      step();
      chk("rd_valid2", 64'(s_valid), 64'd1);
      s_ready = 1'b1; s_rdata = 32'h0000_002A;
      step();
      chk("rd_valid_drop", 64'(s_valid), 64'd0);
      chk("rd_m0_ack", 64'(m0_ack), 64'd1);
      chk("rd_m0_rdata", 64'(m0_rdata), 64'h2A);
      chk("rd_m0_err", 64'(m0_err), 64'd0);
      chk("rd_m1_ack", 64'(m1_ack), 64'd0);
      m0_req = 1'b0; s_ready = 1'b0; s_rdata = 32'h0;
      step();
      chk("rd_ack_pulse", 64'(m0_ack), 64'd0);
      chk("rd_rdata_clr", 64'(m0_rdata), 64'd0);

      // m1 misaligned half write, then size=00
      m1_req = 1'b1; m1_addr = 32'h8000_0001; m1_size = 2'b10; m1_rw = 1'b1; m1_wdata = 32'h1234;
      step();
      chk("mis_m1_ack", 64'(m1_ack), 64'd1);
      chk("mis_m1_err", 64'(m1_err), 64'd1);
      chk("mis_s_valid", 64'(s_valid), 64'd0);
      chk("mis_m0_ack", 64'(m0_ack), 64'd0);
      m1_req = 1'b0;
      step();
      chk("mis_ack_clr", 64'({m1_ack, m1_err}), 64'd0);
      m1_req = 1'b1; m1_addr = 32'h8000_0000; m1_size = 2'b00;
      step();
      chk("none_m1_ack", 64'(m1_ack), 64'd1);
      chk("none_m1_err", 64'(m1_err), 64'd1);
      chk("none_s_valid", 64'(s_valid), 64'd0);
      m1_req = 1'b0;
      step();

      // both requesting continuously, slave always ready: m0,m1,m0,m1 every 3 cycles
      m0_req = 1'b1; m0_addr = 32'h10; m0_size = 2'b11; m0_rw = 1'b0;
      m1_req = 1'b1; m1_addr = 32'h20; m1_size = 2'b11; m1_rw = 1'b1; m1_wdata = 32'h55;
      s_ready = 1'b1; s_rdata = 32'h0000_0077;
      for (int k = 1; k <= 11; k++) begin
         step();
         chk($sformatf("rr_m0_ack_%0d", k), 64'(m0_ack), 64'((k == 2) || (k == 8)));
         chk($sformatf("rr_m1_ack_%0d", k), 64'(m1_ack), 64'((k == 5) || (k == 11)));
         if (k == 2) chk("rr_m0_rdata", 64'(m0_rdata), 64'h77);
         if (k == 5) chk("rr_m1_rdata_wr", 64'(m1_rdata), 64'd0);
         if (k == 4) chk("rr_s_addr_m1", 64'(s_addr), 64'h20);
      end
      m0_req = 1'b0; m1_req = 1'b0; s_ready = 1'b0;
      step();
      step();

      // timeout with s_ready held low
      m0_req = 1'b1; m0_addr = 32'h8000_0004; m0_size = 2'b11; m0_rw = 1'b0;
      s_rdata = 32'hDEAD_BEEF;
      vcnt = 0; got = 1'b0;
      for (int i = 0; i < 40 && !got; i++) begin
         step();
         if (s_valid) vcnt++;
         if (m0_ack) got = 1'b1;
      end
      chk("to_valid_cycles", 64'(vcnt), 64'd15);
      chk("to_ack", 64'(got), 64'd1);
      chk("to_err", 64'(m0_err), 64'd1);
      chk("to_rdata", 64'(m0_rdata), 64'd0);
      m0_req = 1'b0;
      step();

      // s_ready on the 15th BUSY cycle wins over the timeout
      m0_req = 1'b1; m0_addr = 32'h8000_0008; s_rdata = 32'h0000_CAFE;
      for (int i = 0; i < 15; i++) step();
      chk("late_valid", 64'(s_valid), 64'd1);
      chk("late_no_ack", 64'(m0_ack), 64'd0);
      s_ready = 1'b1;
      step();
      chk("late_ack", 64'(m0_ack), 64'd1);
      chk("late_err", 64'(m0_err), 64'd0);
      chk("late_rdata", 64'(m0_rdata), 64'hCAFE);
      m0_req = 1'b0; s_ready = 1'b0;
      step();

      // reset mid-BUSY, then first tie goes to m0
      m1_req = 1'b1; m1_addr = 32'h40; m1_size = 2'b01; m1_rw = 1'b0;
      step();
      chk("mid_busy_valid", 64'(s_valid), 64'd1);
      #2 rst_n = 1'b0;
      #1;
      chk("mid_rst_valid", 64'(s_valid), 64'd0);
      chk("mid_rst_acks", 64'({m1_ack, m0_ack}), 64'd0);
      step();
      rst_n = 1'b1;
      m0_req = 1'b1; m0_addr = 32'h100; m0_size = 2'b11; m0_rw = 1'b0;
      m1_req = 1'b1; m1_addr = 32'h200; m1_size = 2'b11; m1_rw = 1'b0;
      step();
      chk("post_rst_valid", 64'(s_valid), 64'd1);
      chk("post_rst_tie_m0", 64'(s_addr), 64'h100);
      s_ready = 1'b1; s_rdata = 32'h3;
      step();
      chk("post_rst_m0_ack", 64'(m0_ack), 64'd1);
      chk("post_rst_m1_ack", 64'(m1_ack), 64'd0);
      m0_req = 1'b0; m1_req = 1'b0; s_ready = 1'b0;
      step();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
